// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned multiply/divide unit for the execute stage: stalls the pipeline for
// 32 iterations, then presents result and destination register in a one-cycle done pulse.
module ex_muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      rd_e,
   input  logic            flush_e,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [4:0]        count;
   logic [1:0]        op_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_trial;
   logic [XLEN-1:0]   final_val;
   logic              accept;
   logic              complete;

   assign accept   = (state == IDLE) && start && !flush_e;
   assign complete = (state == DONE) && !flush_e;

   always_comb begin
      state_next = state;
      stall_req  = 1'b0;
      unique case (state)
         IDLE: begin
            stall_req = accept;
            if (accept) state_next = BUSY;
         end
         BUSY: begin
            if (flush_e) begin
               state_next = IDLE;
            end else begin
               stall_req = 1'b1;
               if (count == 5'd31) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // acc holds {partial product, multiplier} for MUL/MULHU and {remainder, quotient} for DIVU/REMU
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_trial = div_shift - {1'b0, b_q};
      if (op_q[1]) begin
         if (div_trial[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         else                 acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[XLEN-1:1]};
      end
      final_val = op_q[0] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= IDLE;
         count    <= 5'd0;
         op_q     <= 2'd0;
         rd_q     <= 5'd0;
         b_q      <= {XLEN{1'b0}};
         acc      <= {(2*XLEN){1'b0}};
         result_q <= {XLEN{1'b0}};
         rd_out_q <= 5'd0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q  <= op;
            rd_q  <= rd_e;
            b_q   <= src_b;
            acc   <= {{XLEN{1'b0}}, src_a};
            count <= 5'd0;
         end else if (state == BUSY) begin
            acc   <= acc_next;
            count <= count + 5'd1;
         end
         if (complete) begin
            result_q <= final_val;
            rd_out_q <= rd_q;
         end
      end
   end

   // In DONE the finished value is shown directly so it is stable for the whole done cycle
   assign busy   = (state == BUSY);
   assign done   = complete;
   assign result = complete ? final_val : result_q;
   assign rd_out = complete ? rd_q : rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed and random ops against an arithmetic model,
// with flush/reset aborts and back-to-back issue.
module tb_ex_muldiv_seq;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        srst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  rd_e;
   logic        flush_e;
   logic        stall_req;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;
   logic [31:0] last_result = 32'd0;
   logic [4:0]  last_rd = 5'd0;
   logic        prev_done = 1'b0;

   ex_muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .srst(srst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .rd_e(rd_e), .flush_e(flush_e), .stall_req(stall_req), .busy(busy), .done(done),
      .result(result), .rd_out(rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Issues one op from a negedge; kill_at >= 0 flushes (or resets) the op in cycle T<kill_at>
   task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int kill_at, input bit kill_reset,
                                 input bit chain);
      exp_t e;
      int   last_k;
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      rd_e  = rd;
      if (kill_at < 0) begin
         e.res = model(o, a, b);
         e.rd  = rd;
         e.cyc = cyc + 33;
         exp_q.push_back(e);
      end
      last_k = (kill_at < 0) ? 33 : kill_at;
      for (int k = 0; k <= last_k; k++) begin
         if (k == kill_at) begin
            if (kill_reset) begin
               srst  = 1'b1;
               start = 1'b0;
            end else begin
               flush_e = 1'b1;
            end
         end
         #1;
         if (k == kill_at && !kill_reset) begin
            check_output("stall_flush", {31'd0, stall_req}, 32'd0);
         end else if (k != kill_at) begin
            check_output("stall_req", {31'd0, stall_req}, {31'd0, (k <= 32)});
            check_output("busy", {31'd0, busy}, {31'd0, (k >= 1 && k <= 32)});
         end
         if (k >= 1) begin
            src_a = $urandom;
            src_b = $urandom;
            rd_e  = 5'($urandom);
         end
         @(negedge clk);
      end
      flush_e = 1'b0;
      srst    = 1'b0;
      if (!chain) start = 1'b0;
      if (kill_at >= 0) begin
         #1;
         check_output("kill_busy", {31'd0, busy}, 32'd0);
         check_output("kill_done", {31'd0, done}, 32'd0);
         check_output("kill_stall", {31'd0, stall_req}, {31'd0, start});
         check_output("kill_result", result, kill_reset ? 32'd0 : last_result);
         check_output("kill_rd", {27'd0, rd_out}, kill_reset ? 32'd0 : {27'd0, last_rd});
      end
   endtask

   // Monitor: pops the scoreboard whenever done is seen and checks value, register and latency
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (done) begin
            if (exp_q.size() == 0) begin
               check_output("spurious_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("result", result, e.res);
               check_output("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
               check_output("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            check_output("done_single", {31'd0, prev_done}, 32'd0);
            last_result = result;
            last_rd     = rd_out;
         end
         prev_done = done;
      end
   end

   initial begin
      logic [1:0]  o;
      logic [31:0] b;
      bit          ch;
      srst    = 1'b1;
      start   = 1'b0;
      op      = 2'd0;
      src_a   = 32'd0;
      src_b   = 32'd0;
      rd_e    = 5'd0;
      flush_e = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_output("rst_result", result, 32'd0);
      check_output("rst_rd", {27'd0, rd_out}, 32'd0);
      check_output("rst_flags", {29'd0, stall_req, busy, done}, 32'd0);
      srst = 1'b0;
      @(negedge clk);

      apply_stimulus(2'd0, 32'd7, 32'd6, 5'd5, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, -1, 1'b0, 1'b0);
      idle(2);
      apply_stimulus(2'd2, 32'd100, 32'd7, 5'd3, -1, 1'b0, 1'b1);
      apply_stimulus(2'd3, 32'd100, 32'd7, 5'd4, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd2, 32'd5, 32'd9, 5'd6, -1, 1'b0, 1'b1);
      apply_stimulus(2'd3, 32'd5, 32'd9, 5'd7, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd2, 32'h1234_5678, 32'd0, 5'd8, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd3, 32'h1234_5678, 32'd0, 5'd9, -1, 1'b0, 1'b0);
      idle(1);

      apply_stimulus(2'd0, 32'd11, 32'd13, 5'd10, 10, 1'b0, 1'b1);
      apply_stimulus(2'd2, 32'd1000, 32'd33, 5'd11, -1, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12, 33, 1'b0, 1'b0);
      idle(1);
      apply_stimulus(2'd3, 32'd77, 32'd5, 5'd13, 15, 1'b1, 1'b0);
      idle(5);

      for (int i = 0; i < 20; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         ch = 1'($urandom_range(0, 1));
         apply_stimulus(o, $urandom, b, 5'($urandom), -1, 1'b0, ch);
         if (!ch) idle($urandom_range(0, 2));
      end
      idle(4);
      check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
